// File: rtl/gate_array_pipe_if.sv
//------------------------------------------------------------------------------
// Module : gate_array_pipe_if
// Brief  : Operand/result stream bundle for gate_array_pipe.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface gate_array_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             red_and;
  logic             red_or;
  logic             red_xor;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, red_and, red_or, red_xor, done_cnt
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, red_and, red_or, red_xor, done_cnt
  );
endinterface

`default_nettype wire

// File: rtl/gate_array_pipe.sv
//------------------------------------------------------------------------------
// Module : gate_array_pipe
// Brief  : Two-stage valid/ready pipeline applying one of eight bitwise gates.
//          Define GATE_ARRAY_REDUCE_EN to build the registered y reductions.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gate_array_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_array_pipe_if.slave   bus
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_NAND = 3'b001;
  localparam logic [2:0] c_OP_OR   = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_XNOR = 3'b101;
  localparam logic [2:0] c_OP_NOTA = 3'b110;

  logic             r_s1_v;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_handoff;
  logic [WIDTH-1:0] w_result;

  // Ready path is combinational from out_ready so a full pipe can move every cycle.
  assign w_s2_adv   = !r_s2_v || bus.out_ready;
  assign w_in_ready = !r_s1_v || w_s2_adv;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_handoff  = r_s2_v && bus.out_ready;

  always_comb begin
    w_result = r_s1_a;
    case (r_s1_op)
      c_OP_AND:  w_result = r_s1_a & r_s1_b;
      c_OP_NAND: w_result = ~(r_s1_a & r_s1_b);
      c_OP_OR:   w_result = r_s1_a | r_s1_b;
      c_OP_NOR:  w_result = ~(r_s1_a | r_s1_b);
      c_OP_XOR:  w_result = r_s1_a ^ r_s1_b;
      c_OP_XNOR: w_result = ~(r_s1_a ^ r_s1_b);
      c_OP_NOTA: w_result = ~r_s1_a;
      default:   w_result = r_s1_a;
    endcase
  end

  // Operand registers only load on accept so idle bus data never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s1_op <= 3'b000;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
    end else if (w_in_ready) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_op <= bus.op;
        r_s1_a  <= bus.a;
        r_s1_b  <= bus.b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_y    <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_y <= w_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (w_handoff) begin
      r_done_cnt <= r_done_cnt + CNT_W'(1);
    end
  end

`ifdef GATE_ARRAY_REDUCE_EN
  logic r_red_and;
  logic r_red_or;
  logic r_red_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red_and <= 1'b0;
      r_red_or  <= 1'b0;
      r_red_xor <= 1'b0;
    end else if (w_s2_adv && r_s1_v) begin
      r_red_and <= &w_result;
      r_red_or  <= |w_result;
      r_red_xor <= ^w_result;
    end
  end

  assign bus.red_and = r_red_and;
  assign bus.red_or  = r_red_or;
  assign bus.red_xor = r_red_xor;
`else
  assign bus.red_and = 1'b0;
  assign bus.red_or  = 1'b0;
  assign bus.red_xor = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_v;
  assign bus.y         = r_y;
  assign bus.done_cnt  = r_done_cnt;

endmodule

`default_nettype wire
